// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_pkg
// Brief   : Frame states and line levels shared by the serial tx/rx pair.
// Revision: 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage : serial_frame_pkg
`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : bit_timer
// Brief   : Counts clk cycles within one serial bit, pulses bit_end on the last.
// Revision: 1.0 - initial release
// ============================================================================
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic CLR_L,
    input  logic restart,
    input  logic enable,
    output logic bit_end
);

    localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_end = enable && (r_cnt == c_last);

    always_ff @(posedge clk or negedge CLR_L) begin
        if (!CLR_L) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= bit_end ? '0 : r_cnt + c_one;
        end
    end

endmodule : bit_timer
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_tx
// Brief   : Start/data(LSB first)/[parity]/stop frame transmitter.
//           Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             CLR_L,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             tx,
    output logic             done
);

    localparam int                BCNT_W     = $clog2(WIDTH + 1);
    localparam logic [BCNT_W-1:0] c_last_bit = BCNT_W'(WIDTH - 1);
    localparam logic [BCNT_W-1:0] c_bit_one  = BCNT_W'(1);

    frame_state_t      r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic              r_tx;
    logic              r_done;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_accept;
    logic              w_bit_end;
    logic [WIDTH-1:0]  w_shreg_next;

    assign ready        = (r_state == IDLE);
    assign tx           = r_tx;
    assign done         = r_done;
    assign w_accept     = ready && load;
    assign w_shreg_next = r_shreg >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .CLR_L   (CLR_L),
        .restart (w_accept),
        .enable  (r_state != IDLE),
        .bit_end (w_bit_end)
    );

    // tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state register.
    always_ff @(posedge clk or negedge CLR_L) begin
        if (!CLR_L) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= IDLE_LEVEL;
            r_done    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shreg   <= din;
                        r_bit_cnt <= '0;
                        r_tx      <= START_LEVEL;
                        r_state   <= START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        r_parity  <= ^din;
`endif
                    end else begin
                        r_tx <= IDLE_LEVEL;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shreg[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shreg <= w_shreg_next;
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= PARITY;
`else
                            r_tx      <= STOP_LEVEL;
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                            r_tx      <= w_shreg_next[0];
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= STOP_LEVEL;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_tx    <= IDLE_LEVEL;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_frame_tx
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_frame_tx
// Brief   : Self-checking bench for serial_frame_tx (WIDTH=8, CLKS_PER_BIT=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic             clk = 1'b0;
    logic             CLR_L = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ready;
    logic             tx;
    logic             done;

    int errors = 0;
    int checks = 0;

    serial_frame_tx #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .CLR_L (CLR_L),
        .load  (load),
        .din   (din),
        .ready (ready),
        .tx    (tx),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [10:0] exp_np;
        logic [10:0] exp_p;
        bit          intrude;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: line bit i of a frame, index 0 = start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f = '0;
        f[NBITS-1] = 1'b1;
        for (int i = 0; i < WIDTH; i++) f[i+1] = d[i];
`ifdef SERIAL_FRAME_TX_PARITY_EN
        f[WIDTH+1] = ^d;
`endif
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the accepting edge; ends #1 after the done edge.
    task automatic check_frame(input logic [10:0] exp, input bit intrude);
        for (int k = 0; k < FRAME; k++) begin
            chk("tx_bit", tx, exp[k / CPB]);
            chk("ready_busy", ready, 1'b0);
            chk("done_early", done, 1'b0);
            if (intrude && k == 11) begin
                load = 1'b1;
                din  = 8'hFF;
            end
            if (intrude && k == 12) load = 1'b0;
            step();
        end
        chk("done_pulse", done, 1'b1);
        chk("ready_after", ready, 1'b1);
        chk("tx_idle_after", tx, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] exp, input bit intrude);
        din  = d;
        load = 1'b1;
        step();
        load = 1'b0;
        din  = ~d;
        check_frame(exp, intrude);
        step();
        chk("done_single", done, 1'b0);
        chk("ready_idle", ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [10:0] e;
        vecs[0] = '{8'hA5, 11'h34A, 11'h54A, 1'b1};
        vecs[1] = '{8'h07, 11'h20E, 11'h60E, 1'b0};
        vecs[2] = '{8'h00, 11'h200, 11'h400, 1'b0};
        vecs[3] = '{8'hFF, 11'h3FE, 11'h5FE, 1'b0};
        vecs[4] = '{8'h01, 11'h202, 11'h602, 1'b0};

        // Asynchronous reset between clock edges
        #2 CLR_L = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        step();
        step();
        CLR_L = 1'b1;
        step();

        foreach (vecs[i]) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            e = vecs[i].exp_p;
`else
            e = vecs[i].exp_np;
`endif
            send(vecs[i].din, e, vecs[i].intrude);
        end

        // Back-to-back with load held high; din changes mid-frame are ignored
        din  = 8'h3C;
        load = 1'b1;
        step();
        din  = 8'hC3;
        check_frame(frame_of(8'h3C), 1'b0);
        step();
        load = 1'b0;
        din  = 8'h00;
        check_frame(frame_of(8'hC3), 1'b0);
        step();
        chk("b2b_done_single", done, 1'b0);

        // Reset during data bit 3 (line low), then a clean frame
        din  = 8'h00;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (CPB + 3 * CPB + 1) step();
        chk("pre_rst_tx_low", tx, 1'b0);
        #3 CLR_L = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        for (int k = 0; k < FRAME + 4; k++) begin
            step();
            if (k == 2) CLR_L = 1'b1;
            chk("abandoned_no_done", done, 1'b0);
            chk("abandoned_idle_tx", tx, 1'b1);
        end
        send(8'h01, frame_of(8'h01), 1'b0);

        // Random words with random idle gaps
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int gap;
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                chk("gap_tx", tx, 1'b1);
                chk("gap_ready", ready, 1'b1);
                step();
            end
            send(d, frame_of(d), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_frame_tx
`default_nettype wire
